// File: rtl/soc_system_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_pkg
// Purpose  : Register addresses and parameter encodings shared by the PIO blocks.
// Revision : 1.0
// ============================================================================
package soc_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage
`default_nettype wire

// File: rtl/soc_system_cam_status_in_if.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_cam_status_in_if
// Purpose  : Avalon-MM slave bus bundle for the camera status input PIO.
// Revision : 1.0
// ============================================================================
interface soc_system_cam_status_in_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

endinterface
`default_nettype wire

// File: rtl/soc_system_pio_in_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_in_sync_filter
// Purpose  : Two-flop synchronizer per bit with optional glitch filter
//            (CAM_IN_GLITCH_FILTER_EN) producing the clean input level.
// Revision : 1.0
// ============================================================================
module soc_system_pio_in_sync_filter #(
    parameter int WIDTH         = 8,
    parameter int FILTER_CYCLES = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [WIDTH-1:0] i_async,
    output logic      [WIDTH-1:0] o_level
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("soc_system_pio_in_sync_filter: WIDTH out of range 1..32");
    end
    if (FILTER_CYCLES < 2 || FILTER_CYCLES > 255) begin : g_bad_filter
        $error("soc_system_pio_in_sync_filter: FILTER_CYCLES out of range 2..255");
    end

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

`ifdef CAM_IN_GLITCH_FILTER_EN
    // Each bit follows sync2 only after FILTER_CYCLES consecutive disagreeing samples.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [7:0] r_cnt;
        logic       r_filt;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt  <= '0;
                r_filt <= 1'b0;
            end else if (r_sync2[i] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == 8'(FILTER_CYCLES - 1)) begin
                r_filt <= r_sync2[i];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end

        assign o_level[i] = r_filt;
    end
`else
    assign o_level = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/soc_system_cam_status_in.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_cam_status_in
// Purpose  : Avalon-MM input PIO for camera status lines with edge capture and
//            IRQ; optional glitch filter enabled by CAM_IN_GLITCH_FILTER_EN.
// Revision : 1.0
// ============================================================================
module soc_system_cam_status_in
    import soc_system_pio_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int EDGE_TYPE     = 0,
    parameter int IRQ_MODE      = 1,
    parameter int FILTER_CYCLES = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    soc_system_cam_status_in_if.slave   avs,
    input  wire logic [WIDTH-1:0]       in_port
);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge_cap;
    logic [WIDTH-1:0] r_irq_mask;
    logic [31:0]      w_rd_mux;
    logic [31:0]      r_readdata;
    logic             w_wr;
    logic             w_unused;

    assign w_unused = &{1'b0, avs.writedata};

    soc_system_pio_in_sync_filter #(
        .WIDTH         (WIDTH),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (in_port),
        .o_level (w_level)
    );

    assign w_wr = avs.chipselect & ~avs.write_n;

    if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
        assign w_edge = ~w_level & r_prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
        assign w_edge = w_level ^ r_prev;
    end else begin : g_edge_rise
        assign w_edge = w_level & ~r_prev;
    end

    assign w_clr = (w_wr && avs.address == ADDR_EDGE_CAP) ? avs.writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (avs.address)
            ADDR_DATA:     w_rd_mux = 32'(w_level);
            ADDR_IRQ_MASK: w_rd_mux = 32'(r_irq_mask);
            ADDR_EDGE_CAP: w_rd_mux = 32'(r_edge_cap);
            default:       w_rd_mux = '0;
        endcase
    end

    // A new edge is OR-ed in after the clear so a coincident set survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_edge_cap <= '0;
            r_irq_mask <= '0;
            r_readdata <= '0;
        end else begin
            r_prev     <= w_level;
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            r_readdata <= w_rd_mux;
            if (w_wr && avs.address == ADDR_IRQ_MASK) begin
                r_irq_mask <= avs.writedata[WIDTH-1:0];
            end
        end
    end

    assign avs.readdata = r_readdata;

    if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_level
        assign avs.irq = |(w_level & r_irq_mask);
    end else begin : g_irq_edge
        assign avs.irq = |(r_edge_cap & r_irq_mask);
    end

endmodule
`default_nettype wire
